// File: rtl/lcd_msg_pkg.sv
// Shared message codes and scheduler state encoding for the LCD message scheduler.
package lcd_msg_pkg;

  localparam logic [2:0] MSG_OK_OK    = 3'd0;
  localparam logic [2:0] MSG_LUZ_LOW  = 3'd1;
  localparam logic [2:0] MSG_HUM_LOW  = 3'd2;
  localparam logic [2:0] MSG_BOTH_LOW = 3'd3;
  localparam logic [2:0] MSG_WARN     = 3'd4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SHOW = 2'd1,
    ST_PEND = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;

  // Status code from the two sensor flags: 0 both OK, 1 light low, 2 humidity low, 3 both.
  function automatic logic [2:0] status_code(input logic hum, input logic luz);
    return {1'b0, hum, luz};
  endfunction

endpackage

// File: rtl/lcd_sched_debounce.sv
// Two-flop synchronizer followed by a tick-based debouncer for one sensor flag.
module lcd_sched_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] stab_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Any cycle agreeing with the output restarts the count, so only an unbroken run flips it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      dout     <= 1'b0;
    end else if (sync_p1 == dout) begin
      stab_cnt <= '0;
    end else if (tick) begin
      if (stab_cnt == CW'(DEB_MS - 1)) begin
        dout     <= sync_p1;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_sched.sv
// LCD message scheduler: debounces sensor/alarm flags and commits message changes on frame
// boundaries with a minimum hold time. Define LCD_SCHED_BLINK_EN to blink warning vs status.
module lcd_msg_sched
  import lcd_msg_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DEB_MS   = 20,
  parameter int HOLD_MS  = 500,
  parameter int BLINK_MS = 1000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iHUM_LOW,
  input  logic       iLUZ_LOW,
  input  logic       iALARM,
  input  logic       iFRAME_DONE,
  output logic [2:0] oMSG,
  output logic       oUPD,
  output logic       oWARN
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW       = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          hum_db;
  logic          luz_db;
  logic          alarm_db;
  logic          blink_ph;
  logic [2:0]    target;
  logic [HW-1:0] hold_cnt;
  logic          hold_ok;
  logic          commit;
  sched_state_t  state;
  sched_state_t  state_d;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)   pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  lcd_sched_debounce #(.DEB_MS(DEB_MS)) u_deb_hum (
    .clk(iCLK), .rst_n(iRST_N), .tick(tick), .din(iHUM_LOW), .dout(hum_db)
  );

  lcd_sched_debounce #(.DEB_MS(DEB_MS)) u_deb_luz (
    .clk(iCLK), .rst_n(iRST_N), .tick(tick), .din(iLUZ_LOW), .dout(luz_db)
  );

  lcd_sched_debounce #(.DEB_MS(DEB_MS)) u_deb_alarm (
    .clk(iCLK), .rst_n(iRST_N), .tick(tick), .din(iALARM), .dout(alarm_db)
  );

  assign oWARN = alarm_db;

`ifdef LCD_SCHED_BLINK_EN
  localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  logic [BW-1:0] blink_cnt;

  // Phase restarts at 1 whenever the alarm is idle, so each alarm opens on the warning code.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (!alarm_db) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_MS - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_blink_cfg;

  assign blink_ph         = 1'b1;
  assign unused_blink_cfg = (BLINK_MS > 0);
`endif

  assign target = (alarm_db && blink_ph) ? MSG_WARN : status_code(hum_db, luz_db);

  // Hold timer runs independently of state; hold_ok gates every non-warning commit.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hold_cnt <= '0;
      hold_ok  <= 1'b1;
    end else if (commit) begin
      hold_cnt <= '0;
      hold_ok  <= 1'b0;
    end else if (tick && !hold_ok) begin
      if (hold_cnt == HW'(HOLD_MS - 1)) begin
        hold_cnt <= '0;
        hold_ok  <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    case (state)
      ST_INIT: begin
        if (iFRAME_DONE) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (target != oMSG) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (iFRAME_DONE) begin
          if (target == oMSG) begin
            state_d = hold_ok ? ST_SHOW : ST_HOLD;
          end else if (hold_ok || (target == MSG_WARN)) begin
            commit  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            // Preempted toward warning but the warning vanished: finish the hold first.
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if ((target == MSG_WARN) && (oMSG != MSG_WARN)) state_d = ST_PEND;
        else if (hold_ok)                               state_d = ST_SHOW;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_INIT;
      oMSG  <= MSG_OK_OK;
      oUPD  <= 1'b0;
    end else begin
      state <= state_d;
      oUPD  <= commit;
      if (commit) oMSG <= target;
    end
  end

endmodule

// File: tb/tb_lcd_msg_sched.sv
// Self-checking bench for lcd_msg_sched: directed scenarios plus randomized sensor activity,
// scored against a window-based debounce model and message-commit rules.
module tb_lcd_msg_sched;

  localparam int CLK_HZ   = 10_000;
  localparam int DEB_MS   = 2;
  localparam int HOLD_MS  = 5;
  localparam int BLINK_MS = 10;
  localparam int TDIV     = CLK_HZ / 1000;
  localparam int FRAME_P  = 30;
  localparam int MAXC     = 40000;

`ifdef LCD_SCHED_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hum   = 1'b0;
  logic       luz   = 1'b0;
  logic       alarm = 1'b0;
  logic       frame = 1'b0;
  logic [2:0] msg;
  logic       upd;
  logic       warn;

  lcd_msg_sched #(
    .CLK_HZ(CLK_HZ), .DEB_MS(DEB_MS), .HOLD_MS(HOLD_MS), .BLINK_MS(BLINK_MS)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iHUM_LOW(hum), .iLUZ_LOW(luz), .iALARM(alarm),
    .iFRAME_DONE(frame), .oMSG(msg), .oUPD(upd), .oWARN(warn)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: cycle n counts rising edges since reset release; 1 ms ticks land on
  // multiples of TDIV. A debounced flag flips at a tick once the raw input (seen two edges
  // late through the synchronizer) has disagreed with it over the last DEB_MS ticks.
  bit [2:0] hist [MAXC];
  int       n;
  bit [2:0] m_db;
  int       m_last_eq [3];
  int       m_ticks;
  int       m_blink_ticks;
  bit       m_frame;
  bit [2:0] m_tgt_pre;

  function automatic bit [2:0] tgt_of(input bit [2:0] db, input int bt);
    bit ph;
    ph = !BLINK_ON || (((bt / BLINK_MS) % 2) == 0);
    if (db[2] && ph) return 3'd4;
    return {1'b0, db[1], db[0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_db = 3'b000; m_ticks = 0; m_blink_ticks = 0; m_frame = 1'b0; m_tgt_pre = 3'd0;
      for (int i = 0; i < 3; i++) m_last_eq[i] = 0;
    end else begin
      bit [2:0] raw_d;
      bit       is_tick;
      n++;
      if (n < MAXC) hist[n] = {alarm, hum, luz};
      is_tick   = (n % TDIV) == 0;
      m_frame   = frame;
      m_tgt_pre = tgt_of(m_db, m_blink_ticks);
      raw_d     = (n > 2 && n < MAXC + 2) ? hist[n-2] : 3'b000;
      if (!m_db[2])     m_blink_ticks = 0;
      else if (is_tick) m_blink_ticks++;
      for (int i = 0; i < 3; i++) begin
        if (raw_d[i] == m_db[i]) begin
          m_last_eq[i] = n;
        end else if (is_tick && (m_last_eq[i] < n - TDIV * (DEB_MS - 1))) begin
          m_db[i]      = raw_d[i];
          m_last_eq[i] = n;
        end
      end
      if (is_tick) m_ticks++;
    end
  end

  bit [2:0] prev_msg = 3'd0;
  int       upd_cnt = 0;
  bit       has_commit = 1'b0;
  int       last_commit_ticks = 0;
  int       cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Rules every message change must obey, applied on each cycle out of reset.
  task automatic check_cycle();
    bit chg;
    chg = (msg !== prev_msg);
    if (chg || upd) chk("upd_marks_change", 32'(upd), 32'(chg));
    if (upd) upd_cnt++;
    if (chg) begin
      chk("commit_on_frame", 32'(m_frame), 1);
      chk("commit_value", 32'(msg), 32'(m_tgt_pre));
      chk("msg_in_range", 32'(msg <= 3'd4), 1);
      if (has_commit && msg != 3'd4)
        chk("hold_respected", 32'((m_ticks - last_commit_ticks) >= HOLD_MS), 1);
      has_commit        = 1'b1;
      last_commit_ticks = m_ticks;
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      cyc++;
      if (rst_n) check_cycle();
      prev_msg = msg;
      frame    = ((cyc % FRAME_P) == 0);
    end
  endtask

  task automatic wait_upd(input int limit, output bit ok);
    int start;
    start = upd_cnt;
    ok    = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (upd_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int u0;
    int c1;
    int c2;
    int warn_cyc;
    int rel_cyc;

    rst_n = 1'b0;
    step(3);
    chk("rst_msg", 32'(msg), 0);
    chk("rst_upd", 32'(upd), 0);
    chk("rst_warn", 32'(warn), 0);
    rst_n = 1'b1;

    step(40);
    chk("first_frame_msg", 32'(msg), 0);
    chk("first_frame_no_upd", upd_cnt, 0);

    u0 = upd_cnt; hum = 1'b1;
    step(100);
    chk("hum_low_msg", 32'(msg), 2);
    chk("hum_low_one_upd", upd_cnt - u0, 1);

    step(100);
    u0 = upd_cnt; luz = 1'b1;
    step(TDIV);
    luz = 1'b0;
    step(100);
    chk("glitch_msg", 32'(msg), 2);
    chk("glitch_no_upd", upd_cnt - u0, 0);

    luz = 1'b1;
    wait_upd(150, ok);
    chk("luz_set_upd_seen", 32'(ok), 1);
    c1 = cyc;
    chk("luz_set_msg", 32'(msg), 3);
    step(TDIV);
    luz = 1'b0;
    wait_upd(200, ok);
    chk("luz_clr_upd_seen", 32'(ok), 1);
    c2 = cyc;
    chk("luz_clr_gap_ge_hold", 32'((c2 - c1) >= HOLD_MS * TDIV), 1);
    chk("luz_clr_msg", 32'(msg), 2);

    step(100);
    hum = 1'b0;
    wait_upd(150, ok);
    chk("hum_clr_upd_seen", 32'(ok), 1);
    chk("hum_clr_msg", 32'(msg), 0);
    alarm = 1'b1;
    for (int i = 0; i < 60 && !warn; i++) step(1);
    chk("alarm_warn_rise", 32'(warn), 1);
    warn_cyc = cyc;
    for (int i = 0; i < 40 && msg != 3'd4; i++) step(1);
    chk("alarm_preempt_msg", 32'(msg), 4);
    chk("alarm_next_frame", 32'((cyc - warn_cyc) <= FRAME_P + 1), 1);
    u0 = upd_cnt;
    step(250);
    chk("alarm_warn_level", 32'(warn), 1);
`ifdef LCD_SCHED_BLINK_EN
    chk("alarm_blink_toggles", 32'((upd_cnt - u0) >= 2), 1);
`else
    chk("alarm_steady_msg", 32'(msg), 4);
    chk("alarm_steady_no_upd", upd_cnt - u0, 0);
`endif
    alarm = 1'b0;
    step(300);
    chk("alarm_clr_warn", 32'(warn), 0);
    chk("alarm_clr_msg", 32'(msg), 0);

    for (int it = 0; it < 12; it++) begin
      hum = 1'($urandom_range(0, 1));
      luz = 1'($urandom_range(0, 1));
      step($urandom_range(5, 80));
      if ($urandom_range(0, 3) == 0) begin
        luz = ~luz;
        step($urandom_range(3, 25));
        luz = ~luz;
      end
      if ((it % 4) == 3) begin
        step(250);
        chk("rand_settled_msg", 32'(msg), 32'({hum, luz}));
      end
    end

    hum = 1'b1; luz = 1'b0;
    step(250);
    chk("pre_rst_msg", 32'(msg), 2);
    hum = 1'b0;
    for (int i = 0; i < 60 && m_db[1]; i++) step(1);
    chk("pre_rst_hum_db_fell", 32'(m_db[1]), 0);
    step(1);
    chk("pend_msg_held", 32'(msg), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_msg", 32'(msg), 0);
    chk("async_rst_upd", 32'(upd), 0);
    chk("async_rst_warn", 32'(warn), 0);
    has_commit = 1'b0;
    upd_cnt    = 0;
    step(5);
    chk("rst_held_msg", 32'(msg), 0);
    rst_n   = 1'b1;
    hum     = 1'b1;
    rel_cyc = cyc;
    wait_upd(200, ok);
    chk("post_rst_upd_seen", 32'(ok), 1);
    chk("post_rst_after_debounce", 32'((cyc - rel_cyc) >= DEB_MS * TDIV), 1);
    chk("post_rst_msg", 32'(msg), 2);

    step(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
